// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data load/store share one memory bus.
// Data wins ties until MAX_DSTREAK consecutive data grants, then a waiting fetch goes first.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_wen,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [1:0]        m_wen,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rdy,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, IBUS, DBUS, RESP} state_t;

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [WW-1:0]     WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] NOP        = DATA_W'(32'h0000_0013);

    state_t            state_q;
    logic [SW-1:0]     dstreak_q;
    logic [WW-1:0]     wait_q;
    logic              err_q, i_ack_q, d_ack_q, m_req_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q, i_rdata_q, d_rdata_q;
    logic [1:0]        m_wen_q;
    logic              grant_d;

    // A waiting fetch only loses to data while the data streak is below its cap.
    assign grant_d = d_req && !(i_req && dstreak_q == STREAK_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            m_req_q   <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wen_q   <= 2'b00;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q   <= DBUS;
                        m_req_q   <= 1'b1;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                        m_wen_q   <= d_wen;
                        wait_q    <= '0;
                        if (dstreak_q != STREAK_MAX) dstreak_q <= dstreak_q + SW'(1);
                    end else if (i_req) begin
                        state_q   <= IBUS;
                        m_req_q   <= 1'b1;
                        m_addr_q  <= i_addr;
                        wait_q    <= '0;
                        dstreak_q <= '0;
                    end
                end
                IBUS: begin
                    if (m_rdy) begin
                        i_rdata_q <= m_rdata;
                        i_ack_q   <= 1'b1;
                        m_req_q   <= 1'b0;
                        state_q   <= RESP;
                    end else if (wait_q == WAIT_LAST) begin
                        i_rdata_q <= NOP;
                        err_q     <= 1'b1;
                        i_ack_q   <= 1'b1;
                        m_req_q   <= 1'b0;
                        state_q   <= RESP;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                DBUS: begin
                    if (m_rdy || wait_q == WAIT_LAST) begin
                        // Stores leave d_rdata alone, including an abandoned store.
                        if (m_wen_q == 2'b00) d_rdata_q <= m_rdy ? m_rdata : '0;
                        if (!m_rdy) err_q <= 1'b1;
                        d_ack_q <= 1'b1;
                        m_req_q <= 1'b0;
                        m_wen_q <= 2'b00;
                        state_q <= RESP;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_rdata = i_rdata_q;
    assign i_ack   = i_ack_q;
    assign d_rdata = d_rdata_q;
    assign d_ack   = d_ack_q;
    assign m_req   = m_req_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wen   = m_wen_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a bus-side memory model predicts each access at grant time
// and queues the expected completion; an ack monitor pops and compares.
module tb_mem_arbiter;
    localparam int MAXD = 4;
    localparam int TO   = 15;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, i_ack, d_ack, m_req, m_rdy, busy, err;
    logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [1:0]  d_wen, m_wen;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(MAXD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wen(d_wen),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen),
        .m_rdata(m_rdata), .m_rdy(m_rdy), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] irdata;
        logic [31:0] drdata;
        bit          err;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0, checks = 0;
    int          streak_m = 0, forced_w = -1, n_grants = 0;
    logic [31:0] mi = '0, md = '0;
    bit          merr = 0;
    bit          glog[$];
    bit          s_i, s_d;
    logic [31:0] s_ia, s_da, s_dw;
    logic [1:0]  s_dwen;

    function automatic logic [31:0] memf(logic [31:0] a);
        if (a == 32'h100) return 32'h00A00093;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0001;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Request state as the DUT sampled it at the most recent rising edge.
    always @(posedge clk) begin
        s_i = i_req; s_d = d_req; s_ia = i_addr; s_da = d_addr; s_dw = d_wdata; s_dwen = d_wen;
    end

    // Called at the negedge of the first bus cycle of a new grant.
    task automatic serve();
        bit wd;
        logic [31:0] ea;
        int w;
        exp_t e;
        chk("grant_has_request", {63'b0, s_i | s_d}, 1);
        wd = s_d && !(s_i && streak_m == MAXD);
        ea = wd ? s_da : s_ia;
        if (wd) chk("grant_wdata", m_wdata, s_dw);
        glog.push_back(wd);
        n_grants++;
        streak_m = wd ? ((streak_m < MAXD) ? streak_m + 1 : MAXD) : 0;
        w = (forced_w >= 0) ? forced_w : (($urandom_range(0, 19) == 0) ? 16 : $urandom_range(0, 3));
        if (!wd) mi = (w >= TO) ? NOP : memf(ea);
        else if (s_dwen == 2'b00) md = (w >= TO) ? 32'h0 : memf(ea);
        if (w >= TO) merr = 1;
        e.is_d = wd; e.irdata = mi; e.drdata = md; e.err = merr;
        sbq.push_back(e);
        for (int k = 0; k <= w && k < TO; k++) begin
            if (rst !== 1'b1) break;
            chk("bus_mreq", {63'b0, m_req}, 1);
            chk("bus_addr_hold", m_addr, ea);
            chk("bus_wen", m_wen, wd ? s_dwen : 2'b00);
            m_rdy   = (k == w);
            m_rdata = (k == w) ? memf(ea) : $urandom;
            @(negedge clk);
        end
        m_rdy = 1'b0;
    endtask

    initial begin : memproc
        bit prev;
        prev = 0; m_rdy = 1'b0; m_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && m_req === 1'b1 && !prev) serve();
            prev = m_req;
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst === 1'b1 && (i_ack === 1'b1 || d_ack === 1'b1)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", {62'b0, i_ack, d_ack}, 0);
            end else begin
                e = sbq.pop_front();
                chk("ack_kind", {62'b0, i_ack, d_ack}, e.is_d ? 2'b01 : 2'b10);
                chk("ack_i_rdata", i_rdata, e.irdata);
                chk("ack_d_rdata", d_rdata, e.drdata);
                chk("ack_err", {63'b0, err}, {63'b0, e.err});
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sbq.delete(); streak_m = 0; mi = '0; md = '0; merr = 0;
        rst = 1'b1;
    endtask

    task automatic access(bit is_d, logic [31:0] a, logic [31:0] wdat, logic [1:0] wen, int w,
                          output int cyc, output int nbus);
        bit got;
        @(negedge clk);
        forced_w = w;
        if (is_d) begin d_addr = a; d_wdata = wdat; d_wen = wen; d_req = 1'b1; end
        else begin i_addr = a; i_req = 1'b1; end
        cyc = 0; nbus = 0; got = 0;
        while (cyc < 200 && !got) begin
            @(negedge clk);
            cyc++;
            if ((is_d ? d_ack : i_ack) === 1'b1) got = 1;
            else if (m_req === 1'b1) nbus++;
        end
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
        chk("access_acked", {63'b0, got}, 1);
    endtask

    task automatic rand_i(int n);
        for (int t = 0; t < n; t++) begin
            int c;
            i_addr = 32'($urandom_range(0, 1023)) << 2;
            i_req = 1'b1; c = 0;
            do begin @(negedge clk); c++; end while (i_ack !== 1'b1 && c < 300);
            chk("rand_i_acked", {63'b0, i_ack}, 1);
            if ($urandom_range(0, 1) == 1) begin
                i_req = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        i_req = 1'b0;
    endtask

    task automatic rand_d(int n);
        for (int t = 0; t < n; t++) begin
            int c;
            d_addr = 32'h4000 + (32'($urandom_range(0, 1023)) << 2);
            d_wdata = $urandom; d_wen = 2'($urandom_range(0, 3));
            d_req = 1'b1; c = 0;
            do begin @(negedge clk); c++; end while (d_ack !== 1'b1 && c < 300);
            chk("rand_d_acked", {63'b0, d_ack}, 1);
            if ($urandom_range(0, 1) == 1) begin
                d_req = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        d_req = 1'b0;
    endtask

    initial begin
        int cyc, nbus, g0, cnt;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_wen = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_req", {63'b0, m_req}, 0);
        chk("rst_busy", {63'b0, busy}, 0);
        chk("rst_err", {63'b0, err}, 0);
        chk("rst_acks", {62'b0, i_ack, d_ack}, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_wen", m_wen, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        @(posedge clk); #1 rst = 1'b1;

        // Single fetch, minimum latency
        access(0, 32'h100, 0, 2'b00, 0, cyc, nbus);
        chk("fetch_latency", cyc, 2);
        chk("fetch_bus_cycles", nbus, 1);
        chk("fetch_rdata", i_rdata, 32'h00A00093);

        // Load then word store: store must not disturb d_rdata
        access(1, 32'h3000, 0, 2'b00, 1, cyc, nbus);
        access(1, 32'h2004, 32'hDEADBEEF, 2'b11, 0, cyc, nbus);
        chk("store_keeps_d_rdata", d_rdata, memf(32'h3000));

        // Fairness with both requests held
        do_reset();
        @(negedge clk);
        forced_w = 0; glog.delete(); g0 = n_grants;
        i_addr = 32'h500; d_addr = 32'h600; d_wen = 2'b00;
        i_req = 1'b1; d_req = 1'b1;
        cnt = 0;
        while (n_grants - g0 < 10 && cnt < 200) begin @(negedge clk); cnt++; end
        i_req = 1'b0; d_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("fair_grant_count", {63'b0, glog.size() >= 10}, 1);
        if (glog.size() >= 10)
            for (int k = 0; k < 10; k++)
                chk($sformatf("fair_order_%0d", k), {63'b0, glog[k]}, (k % 5 == 4) ? 0 : 1);

        // Load timeout, then err stays set through a clean fetch
        access(1, 32'h3100, 0, 2'b00, 100, cyc, nbus);
        chk("timeout_bus_cycles", nbus, TO);
        chk("timeout_d_rdata", d_rdata, 0);
        chk("timeout_err", {63'b0, err}, 1);
        access(0, 32'h104, 0, 2'b00, 0, cyc, nbus);
        chk("err_sticky", {63'b0, err}, 1);

        // Reset in the middle of a fetch
        @(negedge clk);
        forced_w = 100; i_addr = 32'h400; i_req = 1'b1;
        cnt = 0;
        while (m_req !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        chk("midrst_granted", {63'b0, m_req}, 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0; i_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_m_req", {63'b0, m_req}, 0);
        chk("midrst_busy", {63'b0, busy}, 0);
        chk("midrst_err", {63'b0, err}, 0);
        @(posedge clk); #1;
        sbq.delete(); streak_m = 0; mi = '0; md = '0; merr = 0;
        rst = 1'b1;
        cnt = 0;
        repeat (20) begin @(negedge clk); if (i_ack === 1'b1) cnt++; end
        chk("midrst_no_ack", cnt, 0);

        // Wait states: ready in the third bus cycle
        access(0, 32'h208, 0, 2'b00, 2, cyc, nbus);
        chk("wait_bus_cycles", nbus, 3);
        chk("wait_latency", cyc, 4);

        // Randomized traffic from both requesters
        forced_w = -1;
        fork
            rand_i(60);
            rand_d(60);
        join
        cnt = 0;
        while (sbq.size() != 0 && cnt < 100) begin @(negedge clk); cnt++; end
        chk("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001: The block SHALL have these parameters: ADDR_W, 32, address width. DATA_W, 32, data width. MAX_DSTREAK, 4, consecutive data grants allowed while an instruction request waits. TIMEOUT, 15, memory-wait cycles before abort.
REQ-002: The block SHALL have these ports, one per line:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- i_req  in  1  instruction fetch request.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched word, registered.
- i_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wen  in  2  00 load, 01 byte, 10 half, 11 word store.
- d_rdata  out  DATA_W  load word, registered.
- d_ack  out  1  one-cycle data completion pulse.
- m_req  out  1  memory access strobe.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory store data.
- m_wen  out  2  memory store type.
- m_rdata  in  DATA_W  memory read data.
- m_rdy  in  1  memory completes the access this cycle.
- busy  out  1  high when state is not IDLE.
- err  out  1  sticky timeout flag.

Function
REQ-003: The FSM SHALL have four states: IDLE, IBUS, DBUS and RESP.
REQ-004: In IDLE with only one request high, the block SHALL grant that request.
REQ-005: In IDLE with both requests high, the block SHALL grant data, unless dstreak equals MAX_DSTREAK, in which case it SHALL grant instruction.
REQ-006: On a grant, the block SHALL latch the winner's address into m_addr; for a data grant it SHALL also latch d_wdata into m_wdata and d_wen into m_wen. The next state SHALL be IBUS (instruction grant) or DBUS (data grant).
REQ-007: dstreak SHALL increment on each data grant, saturating at MAX_DSTREAK, and SHALL clear to 0 on each instruction grant.
REQ-008: m_req SHALL be 1 exactly in IBUS and DBUS. m_wen SHALL be 00 in every state other than DBUS.
REQ-009: In IBUS or DBUS, when m_rdy=1 the block SHALL capture m_rdata into i_rdata (IBUS) or d_rdata (DBUS, loads only) and move to RESP.
REQ-010: On a store, d_rdata SHALL hold its previous value.
REQ-011: In RESP, the block SHALL assert i_ack or d_ack (matching the completed access) for exactly one cycle, then return to IDLE; requests SHALL be ignored during RESP.
REQ-012: Requesters SHALL hold their request and address stable until ack; a request still high in IDLE after an ack SHALL be treated as a new request.
REQ-013: Minimum latency SHALL be: request seen in IDLE at cycle 0, m_req at cycle 1, m_rdy at cycle 1, ack at cycle 2. Peak throughput SHALL be one access per 3 cycles.
REQ-014: A wait counter SHALL count IBUS/DBUS cycles with m_rdy=0. When it reaches TIMEOUT, the block SHALL go to RESP, set err=1, and load i_rdata=32'h00000013 (NOP) or d_rdata=0; an abandoned store SHALL NOT be retried. The wait counter SHALL clear on every grant.
REQ-015: err SHALL remain 1 until reset.
REQ-016: i_rdata and d_rdata SHALL hold their values between completions.
REQ-017: busy SHALL be high in IBUS, DBUS and RESP.

Reset
REQ-018: When rst=0 at a rising clk edge, the block SHALL enter IDLE and clear dstreak, the wait counter, err, i_ack, d_ack, m_req, m_addr, m_wdata, m_wen, i_rdata and d_rdata to 0, including mid-access. The first grant SHALL occur no earlier than the first edge with rst=1.

Verification
REQ-019: Single fetch: i_req=1, i_addr=0x100, m_rdy=1 with m_rdata=0x00A00093 -> m_req at cycle 1 with m_addr=0x100 and m_wen=00; i_ack at cycle 2 with i_rdata=0x00A00093.
REQ-020: Word store: d_req=1, d_addr=0x2004, d_wen=11, d_wdata=0xDEADBEEF -> m_addr=0x2004, m_wen=11, m_wdata=0xDEADBEEF; d_ack pulses once; d_rdata unchanged.
REQ-021: Fairness: i_req and d_req held high continuously with m_rdy=1 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-022: Timeout: d_req load, m_rdy held at 0 -> after 15 DBUS cycles, RESP with d_ack=1, d_rdata=0, err=1; err stays 1 through later successful accesses.
REQ-023: Reset mid-access: rst=0 during IBUS -> next cycle m_req=0, busy=0, err=0, and no i_ack is ever produced for the aborted fetch.
REQ-024: Wait states: m_rdy asserted in the 3rd IBUS cycle -> i_ack exactly 1 cycle later; m_addr held stable through all 3 IBUS cycles.
